// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Round-robin arbiter that lets NCORES matrix cores share one single-port
//   data DRAM. The DRAM reads combinationally and writes on posedge clk.
//   Each cycle at most one eligible core is granted. Its address, data and
//   write enable drive the DRAM directly. The access completes at the next
//   edge with a one-cycle ack and registered read data.
//   The block also aggregates the per-core End flags into a sticky all_done.
//   It fires a single dump_start pulse when all_done first rises.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req/we [NCORES]    per-core request (held until ack) and write enable
//   addr  [NCORES*AW]  packed per-core word addresses
//   wdata [NCORES*DW]  packed per-core write data
//   end_core [NCORES]  per-core program-finished flags
//   ack   [NCORES]     one-cycle completion pulse
//   rdata [NCORES*DW]  per-core read data, valid while the matching ack is high
//   mem_addr/mem_we/mem_wdata/mem_rdata   DRAM port
//   all_done           sticky: all cores ended and the bus is idle
//   dump_start         one-cycle pulse on the rising edge of all_done
//   addr_err           sticky: some granted access was out of range
module dram_port_arbiter #(
  parameter int NCORES = 4,
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int DEPTH  = 3075
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req,
  input  logic [NCORES-1:0]    we,
  input  logic [NCORES*AW-1:0] addr,
  input  logic [NCORES*DW-1:0] wdata,
  input  logic [NCORES-1:0]    end_core,
  output logic [NCORES-1:0]    ack,
  output logic [NCORES*DW-1:0] rdata,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 all_done,
  output logic                 dump_start,
  output logic                 addr_err
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0]    ack_q, ack_d;
  logic [NCORES*DW-1:0] rdata_q, rdata_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 all_done_q, all_done_d;
  logic                 dump_q, dump_d;
  logic                 addr_err_q, addr_err_d;

  logic [NCORES-1:0]    elig;
  logic                 found;
  logic [PW-1:0]        win;
  logic [AW-1:0]        win_addr;
  logic [DW-1:0]        win_wdata;
  logic                 win_we;
  logic                 win_in_range;

  // (p + k) mod NCORES for a pointer value and a small offset k < NCORES.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NCORES) s = s - NCORES;
    return PW'(s);
  endfunction

  // A core whose ack is high this cycle has just been served. It must not win
  // again until it drops or re-presents its request, so it is masked out.
  assign elig = req & ~ack_q;

  // Scan the eligible cores starting at the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!found && elig[wrap_add(ptr_q, k)]) begin
        found = 1'b1;
        win   = wrap_add(ptr_q, k);
      end
    end
  end

  // Grant mux: with no winner the DRAM port is driven to all zeros.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    if (found) begin
      win_addr  = addr[int'(win)*AW +: AW];
      win_wdata = wdata[int'(win)*DW +: DW];
      win_we    = we[win];
    end
  end

  assign win_in_range = (32'(win_addr) < 32'(DEPTH));

  // The write is suppressed for out-of-range addresses and while in reset,
  // so an access dropped by reset never reaches the DRAM.
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;
  assign mem_we    = found & win_we & win_in_range & ~rst;

  always_comb begin
    ack_d      = '0;
    rdata_d    = rdata_q;
    ptr_d      = ptr_q;
    addr_err_d = addr_err_q;
    if (found) begin
      ack_d[win] = 1'b1;
      // Writes and out-of-range reads return zero. Other slots hold.
      rdata_d[int'(win)*DW +: DW] = (win_we || !win_in_range) ? '0 : mem_rdata;
      ptr_d = wrap_add(win, 1);
      if (!win_in_range) addr_err_d = 1'b1;
    end
    // The bus counts as idle only when nothing is requested and no ack is
    // still in flight.
    all_done_d = all_done_q | ((&end_core) && (req == '0) && (ack_q == '0));
    dump_d     = all_done_d & ~all_done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q      <= '0;
      rdata_q    <= '0;
      ptr_q      <= '0;
      all_done_q <= 1'b0;
      dump_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      ptr_q      <= ptr_d;
      all_done_q <= all_done_d;
      dump_q     <= dump_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign all_done   = all_done_q;
  assign dump_start = dump_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Testbench for dram_port_arbiter: a behavioural DRAM is attached to the
// memory port. Each scenario task pushes expected (core, rdata) completions
// into a scoreboard queue as it drives requests. It pops and compares them
// when acks appear.
module tb_dram_port_arbiter;

  localparam int N     = 4;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 3075;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, we, end_core, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            all_done, dump_start, addr_err;

  always #5 clk = ~clk;

  dram_port_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .end_core(end_core), .ack(ack), .rdata(rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .all_done(all_done), .dump_start(dump_start), .addr_err(addr_err)
  );

  // Initial DRAM contents: a fixed address-dependent pattern.
  function automatic logic [DW-1:0] pat(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // DRAM model: combinational read, write on posedge. Out-of-range reads
  // return garbage that the arbiter must replace with zero.
  logic [DW-1:0] dram [0:DEPTH-1];
  bit mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) dram[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (mem_we && mem_addr < 12'(DEPTH)) begin
      dram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_addr < 12'(DEPTH)) ? dram[mem_addr] : 32'hBAD0BAD0;

  typedef struct { int core; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];
  int n_run  = 0;
  int n_fail = 0;

  task automatic set_core(input int c, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = r;
    we[c]  = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic sb_pop(output int c, output logic [DW-1:0] d, output bit ok);
    c = 0; d = '0; ok = 1'b0;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      c = e.core; d = e.data; ok = 1'b1;
    end
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; we = '1; addr = {N{12'h005}}; wdata = '1; end_core = '0;
    for (int i = 0; i < 3; i++) begin
      drive_edge(); @(negedge clk);
      n_run++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
      n_run++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      n_run++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    end
    n_run++; if ({all_done, dump_start, addr_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {all_done, dump_start, addr_err}); end
    drive_edge(); rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    n_run++; if (mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL idle_port: got addr %h we %b wdata %h want 0 0 0", mem_addr, mem_we, mem_wdata); end
  endtask

  task automatic test_single_rw();
    int c; logic [DW-1:0] d; bit ok;
    drive_edge(); set_core(2, 1, 1, 12'h010, 32'hDEADBEEF);
    @(negedge clk);
    n_run++; if (mem_we !== 1'b1 || mem_addr !== 12'h010 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_wr_port: got we %b addr %h data %h want 1 010 deadbeef", mem_we, mem_addr, mem_wdata); end
    n_run++; if (ack !== '0) begin n_fail++; $display("FAIL single_wr_early_ack: got %b want 0", ack); end
    sb.push_back('{core: 2, data: 32'h0});
    drive_edge(); set_core(2, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c)) begin n_fail++; $display("FAIL single_wr_ack: got %b want core %0d", ack, c); end
    n_run++; if (!ok || rdata[c*DW +: DW] !== d) begin n_fail++; $display("FAIL single_wr_rdata: got %h want %h", rdata[c*DW +: DW], d); end
    drive_edge(); set_core(2, 1, 0, 12'h010, '0);
    @(negedge clk);
    n_run++; if (mem_we !== 1'b0 || mem_addr !== 12'h010) begin
      n_fail++; $display("FAIL single_rd_port: got we %b addr %h want 0 010", mem_we, mem_addr); end
    sb.push_back('{core: 2, data: 32'hDEADBEEF});
    drive_edge(); set_core(2, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c)) begin n_fail++; $display("FAIL single_rd_ack: got %b want core %0d", ack, c); end
    n_run++; if (!ok || rdata[c*DW +: DW] !== d) begin n_fail++; $display("FAIL single_rd_rdata: got %h want %h", rdata[c*DW +: DW], d); end
  endtask

  task automatic test_contention();
    int c; logic [DW-1:0] d; bit ok;
    drive_edge(); rst = 1'b1;
    drive_edge(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_core(i, 1, 0, 12'(32'h100 + i), '0);
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) begin
        drive_edge();
        if (t == 8) req = '0;
      end
      @(negedge clk);
      if (t < 8) begin
        n_run++; if (mem_addr !== 12'(32'h100 + t % N)) begin
          n_fail++; $display("FAIL rr_grant_%0d: got addr %h want %h", t, mem_addr, 12'(32'h100 + t % N)); end
        sb.push_back('{core: t % N, data: pat(32'h100 + t % N)});
      end
      if (t > 0) begin
        sb_pop(c, d, ok);
        n_run++; if (!ok || ack !== N'(1 << c)) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want core %0d", t, ack, c); end
        n_run++; if (!ok || rdata[c*DW +: DW] !== d) begin n_fail++; $display("FAIL rr_rdata_%0d: got %h want %h", t, rdata[c*DW +: DW], d); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c; logic [DW-1:0] d; bit ok;
    drive_edge();
    set_core(0, 1, 1, 12'h200, 32'hCAFE0123);
    set_core(1, 1, 0, 12'h200, '0);
    @(negedge clk);
    n_run++; if (mem_we !== 1'b1 || mem_addr !== 12'h200) begin
      n_fail++; $display("FAIL b2b_wr_grant: got we %b addr %h want 1 200", mem_we, mem_addr); end
    sb.push_back('{core: 0, data: 32'h0});
    drive_edge(); set_core(0, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
      n_fail++; $display("FAIL b2b_wr_ack: got ack %b rdata %h want core %0d %h", ack, rdata[c*DW +: DW], c, d); end
    n_run++; if (mem_we !== 1'b0 || mem_addr !== 12'h200) begin
      n_fail++; $display("FAIL b2b_rd_grant: got we %b addr %h want 0 200", mem_we, mem_addr); end
    sb.push_back('{core: 1, data: 32'hCAFE0123});
    drive_edge(); set_core(1, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
      n_fail++; $display("FAIL b2b_rd_ack: got ack %b rdata %h want core %0d %h", ack, rdata[c*DW +: DW], c, d); end
  endtask

  task automatic test_out_of_range();
    int c; logic [DW-1:0] d; bit ok;
    logic [AW-1:0] oa [3];
    bit            ow [3];
    oa = '{12'd3075, 12'h011, 12'd3075};
    ow = '{1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive_edge(); set_core(1, 1, ow[k], oa[k], 32'd1);
      @(negedge clk);
      n_run++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_mem_we_%0d: got %b want 0", k, mem_we); end
      sb.push_back('{core: 1, data: (oa[k] < 12'(DEPTH)) ? pat(int'(oa[k])) : 32'h0});
      drive_edge(); set_core(1, 0, 0, '0, '0);
      @(negedge clk); sb_pop(c, d, ok);
      n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
        n_fail++; $display("FAIL oor_ack_%0d: got ack %b rdata %h want core %0d %h", k, ack, rdata[c*DW +: DW], c, d); end
      n_run++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_addr_err_%0d: got %b want 1", k, addr_err); end
    end
  endtask

  task automatic test_completion();
    int c; logic [DW-1:0] d; bit ok;
    for (int t = 0; t < 8; t++) begin
      drive_edge();
      if (t == 0) begin end_core = '1; set_core(3, 1, 0, 12'h020, '0); end
      if (t == 3) set_core(3, 0, 0, '0, '0);
      if (t == 7) end_core = '0;
      @(negedge clk);
      if (t == 0 || t == 2) sb.push_back('{core: 3, data: pat(32'h020)});
      if (t == 1 || t == 3) begin
        sb_pop(c, d, ok);
        n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
          n_fail++; $display("FAIL done_ack_%0d: got ack %b rdata %h want core %0d %h", t, ack, rdata[c*DW +: DW], c, d); end
      end
      n_run++; if (all_done !== (t >= 5)) begin n_fail++; $display("FAIL all_done_%0d: got %b want %b", t, all_done, (t >= 5)); end
      n_run++; if (dump_start !== (t == 5)) begin n_fail++; $display("FAIL dump_start_%0d: got %b want %b", t, dump_start, (t == 5)); end
    end
  endtask

  task automatic test_midop_reset();
    int c; logic [DW-1:0] d; bit ok;
    drive_edge(); set_core(1, 1, 0, 12'h030, '0);
    @(negedge clk); sb.push_back('{core: 1, data: pat(32'h030)});
    drive_edge(); set_core(1, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
      n_fail++; $display("FAIL pre_rst_ack: got ack %b rdata %h want core %0d %h", ack, rdata[c*DW +: DW], c, d); end
    drive_edge(); set_core(0, 1, 0, 12'h040, '0); rst = 1'b1;
    @(negedge clk);
    drive_edge(); set_core(0, 0, 0, '0, '0); rst = 1'b0;
    @(negedge clk);
    n_run++; if (ack !== '0) begin n_fail++; $display("FAIL midrst_ack: got %b want 0", ack); end
    n_run++; if ({all_done, dump_start, addr_err} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags: got %b want 000", {all_done, dump_start, addr_err}); end
    n_run++; if (rdata !== '0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
    // With the pointer back at 0, core 0 must beat core 3.
    drive_edge(); set_core(0, 1, 0, 12'h050, '0); set_core(3, 1, 0, 12'h053, '0);
    @(negedge clk);
    n_run++; if (mem_addr !== 12'h050) begin n_fail++; $display("FAIL midrst_ptr: got addr %h want 050", mem_addr); end
    sb.push_back('{core: 0, data: pat(32'h050)});
    drive_edge(); set_core(0, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
      n_fail++; $display("FAIL post_rst_ack0: got ack %b rdata %h want core %0d %h", ack, rdata[c*DW +: DW], c, d); end
    n_run++; if (mem_addr !== 12'h053) begin n_fail++; $display("FAIL post_rst_grant3: got addr %h want 053", mem_addr); end
    sb.push_back('{core: 3, data: pat(32'h053)});
    drive_edge(); set_core(3, 0, 0, '0, '0);
    @(negedge clk); sb_pop(c, d, ok);
    n_run++; if (!ok || ack !== N'(1 << c) || rdata[c*DW +: DW] !== d) begin
      n_fail++; $display("FAIL post_rst_ack3: got ack %b rdata %h want core %0d %h", ack, rdata[c*DW +: DW], c, d); end
    n_run++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_rw();
    test_contention();
    test_back_to_back();
    test_out_of_range();
    test_completion();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
